// File: rtl/fifo_rd_packer.sv
// rtl/fifo_rd_packer.sv - read-side FIFO consumer packing LANES entries into one wide word
// Pops whenever the FIFO is non-empty and emits packed words on a valid/ready port with keep bits.
module fifo_rd_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 4
) (
  input  logic                        rclk,
  input  logic                        rrst,
  input  logic                        rempty,
  input  logic [DATA_WIDTH-1:0]       rdata,
  output logic                        rinc,
  input  logic                        flush,
  output logic [DATA_WIDTH*LANES-1:0] out_data,
  output logic [LANES-1:0]            out_keep,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [15:0]                 word_cnt
);

  localparam int              CW   = $clog2(LANES) + 1;
  localparam logic [CW-1:0]   FULL = CW'(LANES);

  logic [LANES-1:0][DATA_WIDTH-1:0] acc;
  logic [LANES-1:0][DATA_WIDTH-1:0] acc_n;
  logic [LANES-1:0][DATA_WIDTH-1:0] packed_n;
  logic [LANES-1:0][DATA_WIDTH-1:0] out_lanes;
  logic [LANES-1:0]                 keep_n;
  logic [CW-1:0]                    lane_cnt;
  logic [CW-1:0]                    lane_cnt_n;
  logic [CW-1:0]                    wr_idx;
  logic                             flush_pend;
  logic                             acc_done;
  logic                             out_free;
  logic                             xfer;
  logic                             accept;

  assign acc_done = (lane_cnt == FULL) || (flush_pend && (lane_cnt != '0));
  assign out_free = !out_valid || out_ready;
  assign xfer     = acc_done && out_free;
  assign accept   = out_valid && out_ready;
  assign rinc     = rrst && !rempty && !flush_pend && ((lane_cnt < FULL) || xfer);
  // A pop sharing the cycle with a transfer starts the next word, so it lands in lane 0.
  assign wr_idx   = xfer ? '0 : lane_cnt;
  assign out_data = out_lanes;

  always_comb begin
    acc_n    = acc;
    packed_n = '0;
    keep_n   = '0;
    for (int i = 0; i < LANES; i++) begin
      if (CW'(i) < lane_cnt) begin
        keep_n[i]   = 1'b1;
        packed_n[i] = acc[i];
      end
      if (rinc && (wr_idx == CW'(i))) begin
        acc_n[i] = rdata;
      end
    end
  end

  always_comb begin
    lane_cnt_n = lane_cnt;
    if (rinc) begin
      lane_cnt_n = xfer ? CW'(1) : lane_cnt + CW'(1);
    end else if (xfer) begin
      lane_cnt_n = '0;
    end
  end

  always_ff @(posedge rclk) begin
    if (!rrst) begin
      acc        <= '0;
      lane_cnt   <= '0;
      flush_pend <= 1'b0;
      out_lanes  <= '0;
      out_keep   <= '0;
      out_valid  <= 1'b0;
      word_cnt   <= '0;
    end else begin
      acc      <= acc_n;
      lane_cnt <= lane_cnt_n;
      // Flush only means something for a partially filled word.
      if (xfer) begin
        flush_pend <= 1'b0;
      end else if (flush && (lane_cnt != '0) && (lane_cnt < FULL)) begin
        flush_pend <= 1'b1;
      end
      if (xfer) begin
        out_lanes <= packed_n;
        out_keep  <= keep_n;
        out_valid <= 1'b1;
      end else if (accept) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        word_cnt <= word_cnt + 16'd1;
      end
    end
  end

endmodule

// File: doc/fifo_rd_packer.md
# fifo_rd_packer

Read-side consumer of the async FIFO, running entirely in the read clock domain. It pops `DATA_WIDTH`-bit entries whenever the FIFO is non-empty and packs `LANES` consecutive entries into one wide word. It presents each packed word on a valid/ready output port with per-lane keep bits. A flush input emits a partially filled word early.

## Interface

**Parameters**
- `DATA_WIDTH`, 8: width of one FIFO entry (`rdata`).
- `LANES`, 4: entries per packed output word; must be ≥ 2.

**Ports**
- `rclk`, in, 1: read-domain clock; all state updates on its rising edge.
- `rrst`, in, 1: reset, synchronous, active-low.
- `rempty`, in, 1: FIFO empty flag, read domain.
- `rdata`, in, `DATA_WIDTH`: FIFO head entry; valid in the same cycle while `rempty`=0 (show-ahead).
- `rinc`, out, 1: pop strobe to the FIFO; combinational.
- `flush`, in, 1: single-cycle request to emit the partial word.
- `out_data`, out, `DATA_WIDTH*LANES`: packed word; lane 0 (first popped) in bits [`DATA_WIDTH`-1:0].
- `out_keep`, out, `LANES`: bit i=1 means lane i holds real data.
- `out_valid`, out, 1: `out_data`/`out_keep` valid.
- `out_ready`, in, 1: downstream accepts the word when high together with `out_valid`.
- `word_cnt`, out, 16: count of words accepted downstream; wraps modulo 2^16.

## Operation

**State**
- Accumulator `acc`: `LANES` lanes of `DATA_WIDTH` bits.
- `lane_cnt`: 0..`LANES`, width clog2(`LANES`)+1.
- `flush_pend`: 1 bit.
- Output register: `out_data`, `out_keep`, `out_valid`.

**Definitions**
- `acc_done` = (`lane_cnt`==`LANES`) OR (`flush_pend` AND `lane_cnt`>0).
- `out_free` = !`out_valid` OR `out_ready`.
- `xfer` = `acc_done` AND `out_free`.

**Pop rule**
- `rinc` = `rrst` AND !`rempty` AND !`flush_pend` AND ((`lane_cnt`<`LANES`) OR `xfer`).
- Never asserted while `rempty`=1. Never asserted while `rrst`=0.

**On pop**
- `rdata` is written into lane `lane_cnt`, or into lane 0 if `xfer` fires in the same cycle.
- `lane_cnt` increments; on a same-cycle `xfer` it becomes 1 instead.

**On xfer**
- `out_data` ← `acc` with unfilled lanes forced to 0.
- `out_keep` ← lowest `lane_cnt` bits set.
- `out_valid` ← 1.
- `lane_cnt` ← 0, unless a same-cycle pop makes it 1.
- `flush_pend` ← 0.

**Handshake and counter**
- Accept (`out_valid` AND `out_ready`) without a same-cycle `xfer`: `out_valid` ← 0.
- Accept with a same-cycle `xfer`: the output reloads back-to-back and `out_valid` stays 1.
- `word_cnt` increments by 1 on every accept.

**Flush**
- `flush` with 0 < `lane_cnt` < `LANES`: set `flush_pend`.
- `flush` with `lane_cnt`==0 or `lane_cnt`==`LANES`: ignored.
- While `flush_pend`=1, pops stop until the partial word has transferred.

**Output stability**
- `out_data` and `out_keep` hold steady while `out_valid`=1 and `out_ready`=0.

**Reset**
- Reset (`rrst`=0 at an edge) zeroes all state: `lane_cnt`, `flush_pend`, `acc`, `out_data`, `out_keep`, `out_valid`, `word_cnt`.
- `rinc` is 0 during reset.
- Reset mid-word discards the partial lanes and any pending output word; nothing is replayed.

## Timing

- Pop in cycle c: the entry is in `acc` from c+1.
- The `LANES`th pop in cycle c: `xfer` in c+1 (if `out_free`); `out_valid`=1 from c+2.
- Sustained throughput: 1 entry per clock with `out_ready` held high and the FIFO non-empty. No bubble at word boundaries, because the pop and the `xfer` share a cycle.
- `out_ready` low with `acc` full: `rinc` drops in the next cycle and stays 0 until the `xfer`.
- `flush` in cycle c with a partial word and `out_free`: `out_valid`=1 from c+2.
- `word_cnt` updates on the edge that ends the accept cycle.

## Test plan

1. **Reset:** hold `rrst`=0 for 3 cycles, FIFO non-empty.
   - Required: `rinc`=0 throughout; all outputs 0.
   - Release reset: the first `rinc` appears in the first cycle after release.
2. **Streaming:** FIFO holds 0x11,0x22,…,0x88 and `out_ready`=1.
   - Required: two words, 0x44332211 then 0x88776655, each with `out_keep`=0xF.
   - `rinc` high for 8 consecutive cycles; `word_cnt`=2.
3. **Backpressure:** `out_ready`=0 with 12 entries available.
   - Required: exactly 8 pops, then `rinc`=0.
   - `out_data` is stable at the first word.
   - Raise `out_ready`: the remaining 4 pop with no bubble.
4. **Flush:** 3 entries 0xAA,0xBB,0xCC, then `flush` pulse.
   - Required: `out_data`=0x00CCBBAA, `out_keep`=0x7.
   - `flush` with `lane_cnt`=0 produces no output.
5. **Empty boundary:** `rempty` toggles every cycle.
   - Required: `rinc` never high while `rempty`=1.
   - Words assemble correctly at half rate.
6. **Reset mid-word:** pop 2 entries, then reset for 1 cycle, then push 0x01..0x04.
   - Required: a single word 0x04030201.
   - Pre-reset lanes are lost; `word_cnt`=1.
